seq_alu: RTL
============

// Module: seq_alu
//
// PURPOSE
// Parametrised, registered ALU with a valid/ready handshake on the operand and result sides.
// Eight operations, including a multi-cycle shift-add multiply, selected by a 3-bit opcode.
// Produces Z/N/C/V status flags with every result.
// Sits between the operand-fetch stage and result writeback in the datapath.
//
// PARAMETERS
// WIDTH  8  operand/result width in bits (>=2)
// CNTW   4  multiply step-counter width; must satisfy 2**CNTW > WIDTH
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      asynchronous, active-high reset
// in_valid   in   1      op/in_a/in_b valid this cycle
// in_ready   out  1      block can accept an operation
// op         in   3      0 ADD, 1 SUB, 2 AND, 3 NOT, 4 OR, 5 XOR, 6 SHL, 7 MUL
// in_a       in   WIDTH  operand A
// in_b       in   WIDTH  operand B (shift amount for SHL; ignored for NOT)
// out_valid  out  1      res/flags valid
// out_ready  in   1      consumer takes result
// res        out  WIDTH  result
// flags      out  4      {Z,N,C,V}
// busy       out  1      high in MUL state
//
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; out_valid=0, res=0, flags=0, busy=0, multiply regs=0.
//   Reset mid-MUL or mid-HOLD aborts the op; the result is discarded.
// - FSM states: IDLE, MUL, HOLD.
// - in_ready = (state==IDLE), combinational from state only.
// - Accept = in_valid & in_ready. The op and operands are captured at accept.
// - IDLE, accept, op!=MUL: result and flags registered that edge; go to HOLD.
//   out_valid=1 on the next cycle (latency 1).
// - IDLE, accept, op==MUL: load multiplicand, multiplier and a 2*WIDTH accumulator (=0); go to MUL.
// - MUL step: one shift-add per cycle; steps run WIDTH times, then go to HOLD.
//   out_valid rises WIDTH+1 cycles after accept.
// - HOLD: res/flags stable while out_valid=1. Leave to IDLE on out_ready=1.
//   Min throughput: 1 op per 2 cycles.
// - Ops are bitwise on WIDTH bits: AND=a&b, OR=a|b, XOR=a^b, NOT=~a.
// - ADD = a+b and SUB = a-b, both mod 2**WIDTH.
// - SHL: res = a << b; res=0 if b>=WIDTH.
// - MUL: unsigned; res = low WIDTH bits of the product.
// - Z = (res==0); N = res[WIDTH-1].
// - C by op:
//   - ADD: carry out.
//   - SUB: borrow, =1 iff a<b unsigned.
//   - MUL: upper WIDTH bits nonzero.
//   - Otherwise 0.
// - V: ADD/SUB two's-complement overflow; 0 for all other ops.
// - in_valid while not IDLE is ignored; the producer must hold until in_ready.
// - out_ready while out_valid=0 has no effect.
// - Opcode values are exhaustive; no illegal op exists.
//
// TESTING
// 1. ADD 8'hFF+8'h01 -> res=8'h00, flags Z=1 C=1 N=0 V=0, out_valid one cycle after accept.
// 2. SUB 8'h80-8'h01 -> res=8'h7F, V=1 C=0.
//    SUB 8'h01-8'h02 -> res=8'hFF, C=1 N=1.
// 3. MUL 8'h10*8'h10 -> res=8'h00, Z=1 C=1, out_valid 9 cycles after accept, busy high 8 cycles.
//    MUL 8'h0C*8'h0A -> res=8'h78, C=0.
// 4. out_ready held 0 for 5 cycles in HOLD -> res/flags stable, in_ready=0.
//    New in_valid ignored until out_ready=1.
// 5. rst asserted at MUL step 4 -> out_valid/busy/res drop to 0 immediately.
//    After release, ADD 3+4 -> res=8'h07.
// 6. SHL a=8'h01, b=7 -> res=8'h80, N=1; b=8 -> res=0, Z=1.
//    NOT 8'h0F -> 8'hF0.
//    AND/OR/XOR of 8'hCC, 8'hAA -> 8'h88 / 8'hEE / 8'h66.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: operand side is producer->ALU,
// result side is ALU->consumer, both valid/ready.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, res, flags, busy
    );

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, res, flags, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops land in HOLD one edge after accept, MUL iterates
// WIDTH shift-add steps first; results hold until out_ready, one op in flight at a time.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH[WIDTH-1:0];
    localparam logic [CNTW-1:0]  LP_LAST  = CNTW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_res;
    logic [3:0]         r_flags;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH-1:0]   w_res_alu;
    logic               w_c_alu;
    logic               w_v_alu;
    logic [3:0]         w_flags_alu;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [3:0]         w_flags_mul;

    assign w_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_dif = {1'b0, bus.in_a} - {1'b0, bus.in_b};

    always_comb begin
        w_res_alu = '0;
        w_c_alu   = 1'b0;
        w_v_alu   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_res_alu = w_sum[WIDTH-1:0];
                w_c_alu   = w_sum[WIDTH];
                w_v_alu   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the zero-extended difference is the borrow (a < b).
                w_res_alu = w_dif[WIDTH-1:0];
                w_c_alu   = w_dif[WIDTH];
                w_v_alu   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                            (w_dif[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_AND:  w_res_alu = bus.in_a & bus.in_b;
            OP_NOT:  w_res_alu = ~bus.in_a;
            OP_OR:   w_res_alu = bus.in_a | bus.in_b;
            OP_XOR:  w_res_alu = bus.in_a ^ bus.in_b;
            OP_SHL:  w_res_alu = (bus.in_b >= LP_WIDTH) ? '0 : (bus.in_a << bus.in_b);
            default: w_res_alu = '0;
        endcase
        w_flags_alu = {(w_res_alu == '0), w_res_alu[WIDTH-1], w_c_alu, w_v_alu};
    end

    assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_flags_mul = {(w_acc_nxt[WIDTH-1:0] == '0), w_acc_nxt[WIDTH-1],
                          (|w_acc_nxt[2*WIDTH-1:WIDTH]), 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_flags  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.op == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, bus.in_a};
                            r_mplier <= bus.in_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_res   <= w_res_alu;
                            r_flags <= w_flags_alu;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNTW'(1);
                    // Final step publishes straight from the adder so HOLD starts this edge.
                    if (r_cnt == LP_LAST) begin
                        r_res   <= w_acc_nxt[WIDTH-1:0];
                        r_flags <= w_flags_mul;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.busy      = (r_state == S_MUL);
    assign bus.res       = r_res;
    assign bus.flags     = r_flags;
endmodule
